// File: rtl/jstk_pkg.sv
// Shared direction codes and sequencer state encodings for the joystick move path.
package jstk_pkg;
  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_DOWN  = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_NONE  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } seqState_t;

  // Codes above DIR_NONE come from an unconnected/odd stick and count as neutral.
  function automatic logic [2:0] normDir(input logic [2:0] d);
    return (d > DIR_NONE) ? DIR_NONE : d;
  endfunction
endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a one-cycle tick every SAMPLE_DIV clocks.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/jstk_move_sequencer.sv
// Debounces joystick direction into single move requests with a req/ack handshake.
// Optional auto-repeat while a deflection is held: define JSTK_AUTO_REPEAT_EN.
module jstk_move_sequencer
  import jstk_pkg::*;
#(
  parameter int SAMPLE_DIV      = 1000000,
  parameter int STABLE_SAMPLES  = 3,
  parameter int NEUTRAL_SAMPLES = 2,
  parameter int REPEAT_SAMPLES  = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dir_in,
  input  logic        game_busy,
  input  logic        move_ack,
  output logic        move_req,
  output logic [1:0]  move_dir,
  output logic [15:0] moves_issued
);
  logic       tick;
  logic [2:0] cand;
  logic [2:0] dirNorm;
  logic [3:0] stableCnt;
  logic       qualified;
  logic       neutralOk;

  seqState_t  state, stateNext;
  logic       reqNext;
  logic [1:0] dirNext;
  logic       ackTaken;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) uTick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign dirNorm = normDir(dir_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand      <= DIR_NONE;
      stableCnt <= '0;
    end else if (tick) begin
      if (dirNorm == cand) begin
        if (stableCnt != 4'd15) stableCnt <= stableCnt + 4'd1;
      end else begin
        cand      <= dirNorm;
        stableCnt <= 4'd1;
      end
    end
  end

  assign qualified = (stableCnt >= 4'(STABLE_SAMPLES)) && (cand != DIR_NONE);
  assign neutralOk = (cand == DIR_NONE) && (stableCnt >= 4'(NEUTRAL_SAMPLES));

`ifdef JSTK_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SAMPLES + 1);
  logic [RW-1:0] repCnt;
  logic          repFire;

  assign repFire = (repCnt >= RW'(REPEAT_SAMPLES));

  // Held at zero outside HOLD, so every HOLD entry starts a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 repCnt <= '0;
    else if (state != HOLD)  repCnt <= '0;
    else if (tick) begin
      if (cand == {1'b0, move_dir}) begin
        if (!repFire) repCnt <= repCnt + 1'b1;
      end else begin
        repCnt <= '0;
      end
    end
  end
`endif

  always_comb begin
    stateNext = state;
    reqNext   = move_req;
    dirNext   = move_dir;
    ackTaken  = 1'b0;
    case (state)
      IDLE: begin
        if (qualified && !game_busy) begin
          dirNext   = cand[1:0];
          reqNext   = 1'b1;
          stateNext = REQ;
        end
      end
      REQ: begin
        if (move_ack) begin
          reqNext   = 1'b0;
          ackTaken  = 1'b1;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (neutralOk) begin
          stateNext = IDLE;
        end
`ifdef JSTK_AUTO_REPEAT_EN
        else if (repFire && !game_busy) begin
          reqNext   = 1'b1;
          stateNext = REQ;
        end
`endif
      end
      default: begin
        stateNext = IDLE;
        reqNext   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      move_req     <= 1'b0;
      move_dir     <= 2'd0;
      moves_issued <= 16'd0;
    end else begin
      state    <= stateNext;
      move_req <= reqNext;
      move_dir <= dirNext;
      if (ackTaken) moves_issued <= moves_issued + 16'd1;
    end
  end
endmodule

// File: tb/tb_jstk_move_sequencer.sv
// Directed self-checking bench for jstk_move_sequencer (SAMPLE_DIV=4, 3/2/5 samples).
module tb_jstk_move_sequencer;
  import jstk_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  dir_in;
  logic        game_busy;
  logic        move_ack;
  logic        move_req;
  logic [1:0]  move_dir;
  logic [15:0] moves_issued;

  int checks = 0;
  int errors = 0;
  int ackMode = 0;  // 0 none, 1 ack two cycles after req rises, 2 ack immediately

  logic [1:0] reqDly = 2'b00;
  logic       prevReq = 1'b0;
  int         rises = 0;
  int         tickCnt = 0;
  int         lastRiseTick = 0;
  int         prevRiseTick = 0;

  jstk_move_sequencer #(
    .SAMPLE_DIV(4), .STABLE_SAMPLES(3), .NEUTRAL_SAMPLES(2), .REPEAT_SAMPLES(5)
  ) dut (
    .clk(clk), .rst(rst), .dir_in(dir_in), .game_busy(game_busy),
    .move_ack(move_ack), .move_req(move_req), .move_dir(move_dir),
    .moves_issued(moves_issued)
  );

  always #5 clk = ~clk;

  assign move_ack = (ackMode == 1) ? (reqDly[1] && move_req) :
                    (ackMode == 2) ? move_req : 1'b0;

  always @(posedge clk) begin
    reqDly  <= {reqDly[0], move_req};
    prevReq <= move_req;
    if (move_req && !prevReq) begin
      rises        <= rises + 1;
      prevRiseTick <= lastRiseTick;
      lastRiseTick <= tickCnt;
    end
    if (dut.tick) tickCnt <= tickCnt + 1;
  end

  task automatic waitTicks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (dut.tick) k++;
    end
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitReq(input int bound, input string name);
    int n = 0;
    while (!move_req && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (move_req !== 1'b1) begin
      errors++;
      $display("FAIL %s: move_req=%b after %0d cycles, required 1", name, move_req, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; dir_in = DIR_NONE; game_busy = 1'b0; ackMode = 0;
    waitCycles(3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", move_req); end
    checks++; if (move_dir !== 2'd0) begin errors++; $display("FAIL reset_dir: got %0d required 0", move_dir); end
    checks++; if (moves_issued !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", moves_issued); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d required IDLE", dut.state); end
    checks++; if (dut.cand !== DIR_NONE) begin errors++; $display("FAIL reset_cand: got %0d required 4", dut.cand); end
    checks++; if (dut.stableCnt !== 4'd0) begin errors++; $display("FAIL reset_stable: got %0d required 0", dut.stableCnt); end
  endtask

  task automatic test_single_move;
    int base;
    ackMode = 1;
    dir_in  = DIR_UP;
    base    = tickCnt;
    waitReq(40, "single_req");
    waitCycles(1);
    checks++; if (lastRiseTick - base !== 3) begin errors++; $display("FAIL single_latency: req after %0d ticks required 3", lastRiseTick - base); end
    checks++; if (move_dir !== 2'd0) begin errors++; $display("FAIL single_dir: got %0d required 0", move_dir); end
    waitCycles(10);
    checks++; if (moves_issued !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d required 1", moves_issued); end
    checks++; if (rises !== 1) begin errors++; $display("FAIL single_once: %0d requests required 1", rises); end
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL single_drop: got %b required 0", move_req); end
  endtask

  task automatic test_unstable;
    int r0;
    dir_in = DIR_NONE;
    waitTicks(3);
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rearm_state: got %0d required IDLE", dut.state); end
    r0 = rises;
    dir_in = DIR_RIGHT; waitTicks(2);
    dir_in = DIR_NONE;  waitTicks(1);
    dir_in = DIR_RIGHT; waitTicks(2);
    dir_in = DIR_NONE;  waitTicks(3);
    checks++; if (rises - r0 !== 0) begin errors++; $display("FAIL unstable_noreq: %0d requests required 0", rises - r0); end
    checks++; if (moves_issued !== 16'd1) begin errors++; $display("FAIL unstable_cnt: got %0d required 1", moves_issued); end
  endtask

  task automatic test_no_neutral;
    int r0;
    dir_in = DIR_LEFT;
    waitReq(40, "left_req");
    checks++; if (move_dir !== 2'd3) begin errors++; $display("FAIL left_dir: got %0d required 3", move_dir); end
    waitTicks(2);
    checks++; if (moves_issued !== 16'd2) begin errors++; $display("FAIL left_cnt: got %0d required 2", moves_issued); end
    r0 = rises;
    dir_in = DIR_RIGHT;
    waitTicks(10);
    checks++; if (rises - r0 !== 0) begin errors++; $display("FAIL swap_noreq: %0d requests required 0", rises - r0); end
    checks++; if (dut.state !== HOLD) begin errors++; $display("FAIL swap_state: got %0d required HOLD", dut.state); end
    dir_in = DIR_NONE;
    waitTicks(2);
    dir_in = DIR_RIGHT;
    waitReq(40, "right_req");
    checks++; if (move_dir !== 2'd2) begin errors++; $display("FAIL right_dir: got %0d required 2", move_dir); end
    waitCycles(6);
    checks++; if (moves_issued !== 16'd3) begin errors++; $display("FAIL right_cnt: got %0d required 3", moves_issued); end
  endtask

  task automatic test_busy;
    dir_in = DIR_NONE;
    waitTicks(3);
    ackMode   = 0;
    game_busy = 1'b1;
    dir_in    = DIR_UP;
    waitTicks(4);
    waitCycles(7);
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL busy_hold: got %b required 0", move_req); end
    @(negedge clk);
    game_busy = 1'b0;
    @(posedge clk); #1;
    checks++; if (move_req !== 1'b1) begin errors++; $display("FAIL busy_release: got %b required 1", move_req); end
    checks++; if (move_dir !== 2'd0) begin errors++; $display("FAIL busy_dir: got %0d required 0", move_dir); end
    dir_in    = DIR_DOWN;
    game_busy = 1'b1;
    waitTicks(4);
    checks++; if (move_req !== 1'b1) begin errors++; $display("FAIL req_held: got %b required 1", move_req); end
    checks++; if (move_dir !== 2'd0) begin errors++; $display("FAIL req_dir_held: got %0d required 0", move_dir); end
    game_busy = 1'b0;
    @(negedge clk);
    ackMode = 2;
    waitCycles(2);
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL busy_ack_drop: got %b required 0", move_req); end
    checks++; if (moves_issued !== 16'd4) begin errors++; $display("FAIL busy_cnt: got %0d required 4", moves_issued); end
  endtask

  task automatic test_reset_mid;
    ackMode = 0;
    dir_in  = DIR_NONE;
    waitTicks(3);
    dir_in = DIR_DOWN;
    waitReq(40, "mid_req");
    #2;
    rst = 1'b1;
    #1;
    checks++; if (move_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b required 0", move_req); end
    checks++; if (moves_issued !== 16'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d required 0", moves_issued); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL mid_rst_state: got %0d required IDLE", dut.state); end
    checks++; if (dut.cand !== DIR_NONE) begin errors++; $display("FAIL mid_rst_cand: got %0d required 4", dut.cand); end
    dir_in = DIR_NONE;
    waitCycles(2);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_auto_repeat;
    int r0;
    ackMode = 2;
    r0      = rises;
    dir_in  = DIR_DOWN;
    waitTicks(30);
    waitCycles(3);
`ifdef JSTK_AUTO_REPEAT_EN
    checks++; if (rises - r0 !== 6) begin errors++; $display("FAIL repeat_count: %0d requests required 6", rises - r0); end
    checks++; if (lastRiseTick - prevRiseTick !== 5) begin errors++; $display("FAIL repeat_period: %0d ticks required 5", lastRiseTick - prevRiseTick); end
    checks++; if (moves_issued !== 16'd6) begin errors++; $display("FAIL repeat_cnt: got %0d required 6", moves_issued); end
`else
    checks++; if (rises - r0 !== 1) begin errors++; $display("FAIL norepeat_count: %0d requests required 1", rises - r0); end
    checks++; if (moves_issued !== 16'd1) begin errors++; $display("FAIL norepeat_cnt: got %0d required 1", moves_issued); end
`endif
    checks++; if (move_dir !== 2'd1) begin errors++; $display("FAIL repeat_dir: got %0d required 1", move_dir); end
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_unstable();
    test_no_neutral();
    test_busy();
    test_reset_mid();
    test_auto_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/jstk_move_sequencer.md
Name: jstk_move_sequencer

Overview:
- Converts the raw 3-bit joystick direction into discrete, debounced game-move requests for the 2048 board logic.
- Samples the direction on a divided tick and requires a stable deflection before issuing a move.
- Issues exactly one move per deflection, handed over with a req/ack handshake.
- Sits between PmodJSTK_Dir and the board/merge engine; holds off while the board is busy.

Parameters:
- SAMPLE_DIV, 1000000, clk cycles per sample tick (100 Hz at 100 MHz); minimum 2.
- STABLE_SAMPLES, 3, consecutive equal samples required to qualify a deflection; range 1..15.
- NEUTRAL_SAMPLES, 2, consecutive neutral samples required to re-arm after a move; range 1..15.
- REPEAT_SAMPLES, 50, hold time in samples before auto-repeat; used only with JSTK_AUTO_REPEAT_EN.

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  asynchronous reset, active-high.
- dir_in  in  3  joystick direction: 0 up, 1 down, 2 right, 3 left, 4 neutral; 5..7 are treated as neutral.
- game_busy  in  1  board engine busy (animating or merging); no new request is started while high.
- move_ack  in  1  board engine accepts the current move.
- move_req  out  1  move request, registered.
- move_dir  out  2  move direction (0 up, 1 down, 2 right, 3 left); stable while move_req is high.
- moves_issued  out  16  count of completed handshakes; wraps at 0xFFFF -> 0.

Behaviour:
- Reset values: move_req=0, move_dir=0, moves_issued=0, tick counter=0, cand=4, stable_cnt=0, state=IDLE.
- Reset is asynchronous. Asserting rst mid-handshake drops move_req immediately; no move is counted.
- Tick generation:
  - Counter runs 0..SAMPLE_DIV-1 and wraps.
  - tick is high for one cycle when the counter equals SAMPLE_DIV-1.
- Sampling on tick:
  - Let d = dir_in, with values 5..7 mapped to 4.
  - If d == cand: stable_cnt increments, saturating at 15.
  - Otherwise: cand <= d and stable_cnt <= 1.
- Derived flags:
  - qualified = (stable_cnt >= STABLE_SAMPLES) && cand != 4.
  - neutral_ok = (cand == 4) && (stable_cnt >= NEUTRAL_SAMPLES).
- FSM state IDLE:
  - On any cycle where qualified && !game_busy: latch move_dir <= cand[1:0], set move_req <= 1, go to REQ.
  - move_req is high the cycle after the condition.
  - If game_busy is high, stay in IDLE. The request fires on the first cycle busy is low, provided the deflection is still qualified.
- FSM state REQ:
  - move_req and move_dir are held.
  - Joystick changes and game_busy are ignored.
  - On the edge where move_ack=1: move_req <= 0, moves_issued increments, go to HOLD.
  - An ack arriving in the same cycle move_req rises counts.
- FSM state HOLD:
  - No requests are issued.
  - Go to IDLE when neutral_ok is true.
  - Changing direction without passing through neutral issues nothing.
- move_ack outside REQ is ignored.
- move_req never pulses twice for one deflection.
- Latency: the first qualifying tick edge is followed by move_req high on the next cycle when not busy. Total delay is STABLE_SAMPLES ticks from the first sample.

Optional Feature:
- Macro: JSTK_AUTO_REPEAT_EN.
- Defined:
  - HOLD keeps a repeat counter, cleared on HOLD entry and incremented on each tick while cand == move_dir.
  - The counter is cleared if cand changes.
  - When the counter reaches REPEAT_SAMPLES and game_busy=0: move_req <= 1 with the same move_dir, go to REQ.
  - neutral_ok still returns to IDLE.
- Undefined:
  - The repeat counter is absent.
  - HOLD exits only through neutral_ok.

Decomposition:
- Package jstk_pkg holds:
  - direction constants DIR_UP=0, DIR_DOWN=1, DIR_RIGHT=2, DIR_LEFT=3, DIR_NONE=4;
  - FSM state encodings IDLE/REQ/HOLD (2 bits).
- Sub-module sample_tick_gen (parameter SAMPLE_DIV; ports clk, rst, tick) holds the divider.

Test Plan (SAMPLE_DIV=4, STABLE_SAMPLES=3, NEUTRAL_SAMPLES=2, REPEAT_SAMPLES=5):
- dir_in=0 held, game_busy=0, move_ack tied to move_req delayed 2 cycles -> one move_req with move_dir=0 after the 3rd tick; moves_issued=1; no further req while held.
- dir_in=2 for 2 ticks, then 4, then 2 for 2 ticks -> no move_req (never stable for 3 samples).
- After one completed move, dir_in goes left->right without neutral for 10 ticks -> no request. Then neutral for 2 ticks, then right for 3 ticks -> move_dir=2, moves_issued=2.
- game_busy=1 while up is qualified, released 7 cycles later -> move_req rises the cycle after busy falls. move_dir stays 0 while dir_in changes during REQ.
- rst pulsed while move_req=1 -> move_req=0 immediately, moves_issued=0, state IDLE, cand=4.
- With JSTK_AUTO_REPEAT_EN, hold down and ack immediately -> requests repeat every 5 ticks after each ack. Without the macro -> exactly one request.
